// File: rtl/decode_uop_seq.sv
// Thumb-16 decode stage: one registered micro-op per instruction, PUSH/POP expanded
// into one micro-op per listed register, with built-in memory/branch wait windows.
module decode_uop_seq #(
  parameter int OFFSET_W = 16,
  parameter int RLIST_W  = 8,
  parameter int MEM_WAIT = 3,
  parameter int BR_WAIT  = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [15:0]         instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic                uop_valid,
  input  logic                uop_ready,
  output logic [4:0]          opcode,
  output logic [3:0]          reg1,
  output logic [3:0]          reg2,
  output logic [3:0]          reg3,
  output logic [OFFSET_W-1:0] offset,
  output logic [3:0]          cond,
  output logic                mem_op,
  output logic                last_uop,
  output logic                busy,
  output logic [1:0]          dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready and the uop fields hold steady while waiting.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXPAND = 2'd1, ST_WAIT = 2'd2} state_t;

  localparam logic [4:0] OP_PUSH = 5'd0,  OP_POP = 5'd1,  OP_SUB_SP = 5'd2,  OP_CMP = 5'd3;
  localparam logic [4:0] OP_MOVS = 5'd4,  OP_MOV = 5'd5,  OP_LDR = 5'd6,     OP_STR = 5'd7;
  localparam logic [4:0] OP_LDR_NOP = 5'd8, OP_ADD_SP = 5'd9, OP_BRANCH_NC = 5'd10;
  localparam logic [4:0] OP_ADDS_3OP = 5'd11, OP_BRANCH_C = 5'd12, OP_STRB = 5'd13;
  localparam logic [4:0] OP_LDRB = 5'd14, OP_ADDS_2OP = 5'd15, OP_NOP = 5'd16;

  state_t              state_q, state_d;
  logic                uop_valid_q, uop_valid_d;
  logic [4:0]          opcode_q, opcode_d;
  logic [3:0]          reg1_q, reg1_d, reg2_q, reg2_d, reg3_q, reg3_d, cond_q, cond_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                mem_op_q, mem_op_d, last_q, last_d, push_q, push_d;
  logic [15:0]         rem_q, rem_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [4:0]          dec_op;
  logic [3:0]          dec_r1, dec_r2, dec_r3, dec_cond, pick_r;
  logic [OFFSET_W-1:0] dec_off;
  logic [15:0]         dec_mask, src_mask, rest_mask;
  logic                dec_list, dec_push, src_push, list_last, uop_hs, accept;
  logic [7:0]          wait_len;

  function automatic logic is_mem(input logic [4:0] op);
    return op inside {OP_PUSH, OP_POP, OP_LDR, OP_STR, OP_LDR_NOP, OP_STRB, OP_LDRB};
  endfunction

  function automatic logic is_br(input logic [4:0] op);
    return op inside {OP_BRANCH_NC, OP_BRANCH_C};
  endfunction

  // hi_first picks the highest set bit (PUSH order), otherwise the lowest (POP order).
  function automatic logic [3:0] pick_reg(input logic [15:0] m, input logic hi_first);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (hi_first && m[i]) r = 4'(i);
      if (!hi_first && m[15-i]) r = 4'(15 - i);
    end
    return r;
  endfunction

  always_comb begin
    dec_op   = OP_NOP;
    dec_r1   = '0;
    dec_r2   = '0;
    dec_r3   = '0;
    dec_off  = '0;
    dec_cond = '0;
    dec_mask = '0;
    dec_list = 1'b0;
    dec_push = 1'b0;
    casez (instr)
      16'b0010_0???_????_????: begin dec_op = OP_MOVS; dec_r3 = {1'b0, instr[10:8]};
        dec_off = OFFSET_W'(instr[7:0]); end
      16'b0010_1???_????_????: begin dec_op = OP_CMP; dec_r1 = {1'b0, instr[10:8]};
        dec_off = OFFSET_W'(instr[7:0]); end
      16'b0011_0???_????_????: begin dec_op = OP_ADDS_2OP; dec_r1 = {1'b0, instr[10:8]};
        dec_r3 = {1'b0, instr[10:8]}; dec_off = OFFSET_W'(instr[7:0]); end
      16'b0001_110?_????_????: begin dec_op = OP_ADDS_3OP; dec_r1 = {1'b0, instr[5:3]};
        dec_r3 = {1'b0, instr[2:0]}; dec_off = OFFSET_W'(instr[8:6]); end
      16'b0100_0110_????_????: begin dec_op = OP_MOV; dec_r1 = instr[6:3];
        dec_r3 = {instr[7], instr[2:0]}; end
      16'b0100_1???_????_????: begin dec_op = OP_LDR; dec_r1 = 4'd15;
        dec_r3 = {1'b0, instr[10:8]}; dec_off = OFFSET_W'({instr[7:0], 2'b00}); end
      16'b0101_010?_????_????: begin dec_op = OP_STRB; dec_r1 = {1'b0, instr[8:6]};
        dec_r2 = {1'b0, instr[5:3]}; dec_r3 = {1'b0, instr[2:0]}; end
      16'b0101_110?_????_????: begin dec_op = OP_LDRB; dec_r1 = {1'b0, instr[8:6]};
        dec_r2 = {1'b0, instr[5:3]}; dec_r3 = {1'b0, instr[2:0]}; end
      16'b0110_0???_????_????: begin dec_op = OP_STR; dec_r1 = {1'b0, instr[5:3]};
        dec_r2 = {1'b0, instr[2:0]}; dec_off = OFFSET_W'({instr[10:6], 2'b00}); end
      16'b0110_1???_????_????: begin dec_op = OP_LDR_NOP; dec_r1 = {1'b0, instr[5:3]};
        dec_r3 = {1'b0, instr[2:0]}; dec_off = OFFSET_W'({instr[10:6], 2'b00}); end
      16'b1010_1???_????_????: begin dec_op = OP_ADD_SP; dec_r1 = 4'd13;
        dec_r3 = {1'b0, instr[10:8]}; dec_off = OFFSET_W'({instr[7:0], 2'b00}); end
      16'b1011_0000_1???_????: begin dec_op = OP_SUB_SP; dec_r1 = 4'd13; dec_r3 = 4'd13;
        dec_off = OFFSET_W'({instr[6:0], 2'b00}); end
      16'b1011_?10?_????_????: begin
        // PUSH (bit11=0) carries LR in bit 8, POP (bit11=1) carries PC in bit 8.
        dec_push = !instr[11];
        dec_mask = 16'(instr[RLIST_W-1:0]);
        dec_mask[14] = instr[8] && !instr[11];
        dec_mask[15] = instr[8] && instr[11];
        dec_list = (dec_mask != '0);
      end
      16'b1101_????_????_????: if (instr[11:9] != 3'b111) begin
        dec_op = OP_BRANCH_C; dec_cond = instr[11:8];
        dec_off = OFFSET_W'($signed({instr[7:0], 1'b0}));
      end
      16'b1110_0???_????_????: begin dec_op = OP_BRANCH_NC;
        dec_off = OFFSET_W'($signed({instr[10:0], 1'b0})); end
      default: dec_op = OP_NOP;
    endcase
  end

  assign uop_hs      = uop_valid_q && uop_ready;
  assign instr_ready = (state_q == ST_IDLE) && (!uop_valid_q || uop_ready) && !flush;
  assign accept      = instr_valid && instr_ready;
  assign wait_len    = mem_op_q ? 8'(MEM_WAIT) : 8'(BR_WAIT);
  assign src_mask    = (state_q == ST_EXPAND) ? rem_q : dec_mask;
  assign src_push    = (state_q == ST_EXPAND) ? push_q : dec_push;
  assign pick_r      = pick_reg(src_mask, src_push);
  assign rest_mask   = src_mask & ~(16'd1 << pick_r);
  assign list_last   = (rest_mask == '0);

  always_comb begin
    state_d     = state_q;
    uop_valid_d = uop_valid_q;
    opcode_d    = opcode_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    reg3_d      = reg3_q;
    offset_d    = offset_q;
    cond_d      = cond_q;
    mem_op_d    = mem_op_q;
    last_d      = last_q;
    rem_d       = rem_q;
    push_d      = push_q;
    cnt_d       = cnt_q;
    if (flush) begin
      state_d     = ST_IDLE;
      uop_valid_d = 1'b0;
      rem_d       = '0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (uop_hs) uop_valid_d = 1'b0;
          if (accept) begin
            uop_valid_d = 1'b1;
            reg2_d      = dec_r2;
            cond_d      = dec_cond;
            cnt_d       = '0;
            if (dec_list) begin
              opcode_d = dec_push ? OP_PUSH : OP_POP;
              reg1_d   = 4'd13;
              reg3_d   = pick_r;
              offset_d = '0;
              mem_op_d = 1'b1;
              last_d   = list_last;
              rem_d    = rest_mask;
              push_d   = dec_push;
              state_d  = list_last ? ST_WAIT : ST_EXPAND;
            end else begin
              opcode_d = dec_op;
              reg1_d   = dec_r1;
              reg3_d   = dec_r3;
              offset_d = dec_off;
              mem_op_d = is_mem(dec_op);
              last_d   = 1'b1;
              // Holding in WAIT while the uop is pending keeps new work out.
              if (is_mem(dec_op) || is_br(dec_op)) state_d = ST_WAIT;
            end
          end
        end
        ST_EXPAND: if (uop_hs) begin
          reg3_d   = pick_r;
          offset_d = offset_q + OFFSET_W'(4);
          last_d   = list_last;
          rem_d    = rest_mask;
          if (list_last) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (uop_valid_q) begin
            if (uop_hs) begin
              uop_valid_d = 1'b0;
              if (wait_len == '0) state_d = ST_IDLE;
              else cnt_d = wait_len;
            end
          end else if (cnt_q <= 8'd1) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      uop_valid_q <= 1'b0;
      opcode_q    <= OP_NOP;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      offset_q    <= '0;
      cond_q      <= '0;
      mem_op_q    <= 1'b0;
      last_q      <= 1'b0;
      rem_q       <= '0;
      push_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      uop_valid_q <= uop_valid_d;
      opcode_q    <= opcode_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      reg3_q      <= reg3_d;
      offset_q    <= offset_d;
      cond_q      <= cond_d;
      mem_op_q    <= mem_op_d;
      last_q      <= last_d;
      rem_q       <= rem_d;
      push_q      <= push_d;
      cnt_q       <= cnt_d;
    end
  end

  assign uop_valid = uop_valid_q;
  assign opcode    = opcode_q;
  assign reg1      = reg1_q;
  assign reg2      = reg2_q;
  assign reg3      = reg3_q;
  assign offset    = offset_q;
  assign cond      = cond_q;
  assign mem_op    = mem_op_q;
  assign last_uop  = last_q;
  assign busy      = (state_q != ST_IDLE) || uop_valid_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_decode_uop_seq.sv
// Bench for decode_uop_seq: directed scenarios plus random instructions checked
// against an instruction-level reference model of the expected micro-op stream.
module tb_decode_uop_seq;
  localparam int MEM_WAIT = 3;
  localparam int BR_WAIT  = 2;
  localparam int RL       = 8;
  localparam int UW       = 39;

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  r3;
    logic [15:0] off;
    logic [3:0]  cond;
    logic        mem;
    logic        last;
  } uop_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        uop_ready = 1'b0;
  logic        instr_ready, uop_valid, mem_op, last_uop, busy;
  logic [4:0]  opcode;
  logic [3:0]  reg1, reg2, reg3, cond;
  logic [15:0] offset;
  logic [1:0]  dbg_state;

  logic [UW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  decode_uop_seq #(.OFFSET_W(16), .RLIST_W(RL), .MEM_WAIT(MEM_WAIT), .BR_WAIT(BR_WAIT)) dut (
    .clk(clk), .reset(reset), .flush(flush), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .uop_valid(uop_valid), .uop_ready(uop_ready),
    .opcode(opcode), .reg1(reg1), .reg2(reg2), .reg3(reg3), .offset(offset), .cond(cond),
    .mem_op(mem_op), .last_uop(last_uop), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [UW-1:0] dut_uop();
    return {opcode, reg1, reg2, reg3, offset, cond, mem_op, last_uop};
  endfunction

  // Reference model: appends the expected uops of one instruction, returns its wait.
  task automatic model_instr(input logic [15:0] ins, output int w);
    uop_t u;
    int   regs[$];
    int   v;
    logic is_list;
    u = '0;
    u.op = 5'd16;
    u.last = 1'b1;
    w = 0;
    is_list = 1'b0;
    if (ins[15:11] == 5'b00100) begin
      u.op = 5'd4; u.r3 = 4'(ins[10:8]); u.off = 16'(ins[7:0]);
    end else if (ins[15:11] == 5'b00101) begin
      u.op = 5'd3; u.r1 = 4'(ins[10:8]); u.off = 16'(ins[7:0]);
    end else if (ins[15:11] == 5'b00110) begin
      u.op = 5'd15; u.r1 = 4'(ins[10:8]); u.r3 = 4'(ins[10:8]); u.off = 16'(ins[7:0]);
    end else if (ins[15:9] == 7'b0001110) begin
      u.op = 5'd11; u.r1 = 4'(ins[5:3]); u.r3 = 4'(ins[2:0]); u.off = 16'(ins[8:6]);
    end else if (ins[15:8] == 8'h46) begin
      u.op = 5'd5; u.r1 = 4'(ins[6:3]); u.r3 = 4'(int'(ins[7]) * 8 + int'(ins[2:0]));
    end else if (ins[15:11] == 5'b01001) begin
      u.op = 5'd6; u.r1 = 4'd15; u.r3 = 4'(ins[10:8]); u.off = 16'(int'(ins[7:0]) * 4);
    end else if (ins[15:9] == 7'b0101010 || ins[15:9] == 7'b0101110) begin
      u.op = ins[11] ? 5'd14 : 5'd13;
      u.r1 = 4'(ins[8:6]); u.r2 = 4'(ins[5:3]); u.r3 = 4'(ins[2:0]);
    end else if (ins[15:11] == 5'b01100) begin
      u.op = 5'd7; u.r1 = 4'(ins[5:3]); u.r2 = 4'(ins[2:0]); u.off = 16'(int'(ins[10:6]) * 4);
    end else if (ins[15:11] == 5'b01101) begin
      u.op = 5'd8; u.r1 = 4'(ins[5:3]); u.r3 = 4'(ins[2:0]); u.off = 16'(int'(ins[10:6]) * 4);
    end else if (ins[15:11] == 5'b10101) begin
      u.op = 5'd9; u.r1 = 4'd13; u.r3 = 4'(ins[10:8]); u.off = 16'(int'(ins[7:0]) * 4);
    end else if (ins[15:7] == 9'b101100001) begin
      u.op = 5'd2; u.r1 = 4'd13; u.r3 = 4'd13; u.off = 16'(int'(ins[6:0]) * 4);
    end else if (ins[15:9] == 7'b1011010) begin
      is_list = 1'b1;
      if (ins[8]) regs.push_back(14);
      for (int r = RL - 1; r >= 0; r--) if (ins[r]) regs.push_back(r);
    end else if (ins[15:9] == 7'b1011110) begin
      is_list = 1'b1;
      for (int r = 0; r < RL; r++) if (ins[r]) regs.push_back(r);
      if (ins[8]) regs.push_back(15);
    end else if (ins[15:12] == 4'hD && int'(ins[11:8]) < 14) begin
      v = int'(ins[7:0]);
      if (v >= 128) v -= 256;
      u.op = 5'd12; u.cond = ins[11:8]; u.off = 16'(v * 2);
    end else if (ins[15:11] == 5'b11100) begin
      v = int'(ins[10:0]);
      if (v >= 1024) v -= 2048;
      u.op = 5'd10; u.off = 16'(v * 2);
    end
    if (is_list && regs.size() > 0) begin
      for (int k = 0; k < regs.size(); k++) begin
        u.op = ins[11] ? 5'd1 : 5'd0;
        u.r1 = 4'd13; u.r3 = 4'(regs[k]); u.off = 16'(4 * k);
        u.mem = 1'b1; u.last = (k == regs.size() - 1);
        exp_q.push_back(u);
      end
      w = MEM_WAIT;
    end else begin
      u.mem = (u.op inside {5'd6, 5'd7, 5'd8, 5'd13, 5'd14});
      if (u.mem) w = MEM_WAIT;
      if (u.op == 5'd10 || u.op == 5'd12) w = BR_WAIT;
      exp_q.push_back(u);
    end
  endtask

  // Offers one instruction, drains its uops with random back-pressure, then measures
  // how long instr_ready stays low after the final handshake.
  task automatic send(input logic [15:0] ins, input int pct, input int hold);
    int w, guard, low;
    logic done, stalled, exp_rdy;
    logic [UW-1:0] cur, held, e;
    model_instr(ins, w);
    @(negedge clk);
    instr = ins; instr_valid = 1'b1; uop_ready = 1'b0;
    #1;
    guard = 0;
    while (!instr_ready && guard < 20) begin @(negedge clk); #1; guard++; end
    check("accept_ready", 64'(instr_ready), 64'(1));
    @(negedge clk);
    instr_valid = 1'b0;
    done = 1'b0; stalled = 1'b0; guard = 0; held = '0;
    while (!done && guard < 300 && exp_q.size() > 0) begin
      if (hold > 0) begin uop_ready = 1'b0; hold--; end
      else uop_ready = ($urandom_range(0, 99) < pct);
      #1;
      cur = dut_uop();
      e = exp_q[0];
      check("uop_valid", 64'(uop_valid), 64'(1));
      if (stalled) check("uop_stable", 64'(cur), 64'(held));
      exp_rdy = (e[0] && w == 0) ? uop_ready : 1'b0;
      check("instr_ready_busy", 64'(instr_ready), 64'(exp_rdy));
      if (uop_ready) begin
        void'(exp_q.pop_front());
        check("uop", 64'(cur), 64'(e));
        done = e[0];
        stalled = 1'b0;
      end else begin
        held = cur;
        stalled = 1'b1;
      end
      @(negedge clk);
      guard++;
    end
    if (!done) begin check("drain_timeout", 64'(0), 64'(1)); exp_q.delete(); end
    uop_ready = 1'($urandom_range(0, 1));
    #1;
    check("uop_valid_after", 64'(uop_valid), 64'(0));
    low = 0;
    while (!instr_ready && low < 20) begin @(negedge clk); #1; low++; end
    check("wait_cycles", 64'(low), 64'(w));
  endtask

  logic [15:0] bases[17] = '{16'h2000, 16'h2800, 16'h3000, 16'h1C00, 16'h4600, 16'h4800,
                             16'h6000, 16'h6800, 16'h5400, 16'h5C00, 16'hA800, 16'hB080,
                             16'hB400, 16'hBC00, 16'hD000, 16'hE000, 16'h0000};
  logic [15:0] masks[17] = '{16'h07FF, 16'h07FF, 16'h07FF, 16'h01FF, 16'h00FF, 16'h07FF,
                             16'h07FF, 16'h07FF, 16'h01FF, 16'h01FF, 16'h07FF, 16'h007F,
                             16'h01FF, 16'h01FF, 16'h0FFF, 16'h07FF, 16'hFFFF};

  initial begin
    int k;
    logic [15:0] ins;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_uop_valid", 64'(uop_valid), 64'(0));
    check("rst_fields", 64'(dut_uop()), 64'({5'd16, 34'd0}));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_instr_ready", 64'(instr_ready), 64'(1));

    // MOVS then ADDS back to back
    @(negedge clk);
    instr = 16'h2305; instr_valid = 1'b1; uop_ready = 1'b1;
    #1 check("b2b_ready0", 64'(instr_ready), 64'(1));
    @(negedge clk);
    instr = 16'h1C5A;
    #1;
    check("b2b_movs", 64'({uop_valid, opcode, reg3, offset}), 64'({1'b1, 5'd4, 4'd3, 16'd5}));
    check("b2b_ready1", 64'(instr_ready), 64'(1));
    @(negedge clk);
    instr_valid = 1'b0;
    #1;
    check("b2b_adds", 64'({uop_valid, opcode, reg1, reg3, offset}),
          64'({1'b1, 5'd11, 4'd3, 4'd2, 16'd1}));
    @(negedge clk);
    #1 check("b2b_drained", 64'(uop_valid), 64'(0));

    // Directed spec scenarios through the model
    send(16'hB512, 100, 0);
    send(16'hD1FF, 60, 0);
    send(16'h4802, 100, 4);
    send(16'hFFFF, 100, 0);
    send(16'hB400, 70, 0);

    // POP {r0-r7,pc} with flush on the third uop
    @(negedge clk);
    instr = 16'hBDFF; instr_valid = 1'b1; uop_ready = 1'b0;
    #1 check("pop_accept", 64'(instr_ready), 64'(1));
    @(negedge clk);
    instr_valid = 1'b0; uop_ready = 1'b1;
    #1 check("pop_uop0", 64'({opcode, reg1, reg3, offset}), 64'({5'd1, 4'd13, 4'd0, 16'd0}));
    @(negedge clk);
    #1 check("pop_uop1", 64'({reg3, offset, last_uop}), 64'({4'd1, 16'd4, 1'b0}));
    @(negedge clk);
    flush = 1'b1; instr = 16'h2305; instr_valid = 1'b1;
    #1;
    check("pop_uop2", 64'({reg3, offset, uop_valid}), 64'({4'd2, 16'd8, 1'b1}));
    check("flush_ready", 64'(instr_ready), 64'(0));
    @(negedge clk);
    flush = 1'b0; instr_valid = 1'b0;
    #1;
    check("flush_valid", 64'(uop_valid), 64'(0));
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_ready_after", 64'(instr_ready), 64'(1));

    // reset during WAIT
    @(negedge clk);
    instr = 16'h4802; instr_valid = 1'b1; uop_ready = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1 check("wait_entered", 64'(instr_ready), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wait_fields", 64'({uop_valid, dut_uop(), busy}), 64'({1'b0, 5'd16, 34'd0, 1'b0}));
    check("rst_wait_ready", 64'(instr_ready), 64'(1));

    // random instruction mix against the model
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 16);
      ins = bases[k] | (16'($urandom) & masks[k]);
      send(ins, $urandom_range(30, 100), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
